fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline: owns `program_counter`, drives the instruction-memory address, and loads the IF/ID pipeline register consumed by decode and `regFile`. It loads the start address from the top-level PC value input after reset. It honours stall, flush and branch/jump redirect requests from the downstream hazard and branch logic.

---
 rtl/mips_pkg.sv | 30 +++
 rtl/fetch_stage_if.sv | 39 +++
 rtl/if_id_reg.sv | 36 +++
 rtl/fetch_stage.sv | 107 ++++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS fetch stage.
//   XLEN          - datapath/address width
//   PC_STEP       - byte increment per sequential fetch
//   fetch_state_t - fetch FSM states {S_INIT, S_RUN, S_HALT}
//   if_id_t       - IF/ID pipeline register contents {instr, pc, pc4, valid}
//   align_word()  - clears the two byte-offset bits of an address
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  // Instruction fetches are word aligned: drop the byte offset.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: bundles the fetch stage's memory bus, hazard/branch
// control inputs and IF/ID outputs.
//   master modport - used by fetch_stage (drives address, PC, IF/ID, status)
//   slave modport  - used by the surrounding pipeline / memory model
// Signals: pc_init, imem_addr, imem_rdata, stall, flush, redirect_valid,
//   redirect_pc, halt_req, program_counter, if_id_instr, if_id_pc,
//   if_id_pc4, if_id_valid, pc_misalign, cycle_count.
interface fetch_stage_if;
  import mips_pkg::*;

  logic [XLEN-1:0] pc_init;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            stall;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halt_req;
  logic [XLEN-1:0] program_counter;
  logic [31:0]     if_id_instr;
  logic [XLEN-1:0] if_id_pc;
  logic [XLEN-1:0] if_id_pc4;
  logic            if_id_valid;
  logic            pc_misalign;
  logic [31:0]     cycle_count;

  modport master (
    input  pc_init, imem_rdata, stall, flush, redirect_valid, redirect_pc, halt_req,
    output imem_addr, program_counter, if_id_instr, if_id_pc, if_id_pc4,
           if_id_valid, pc_misalign, cycle_count
  );

  modport slave (
    output pc_init, imem_rdata, stall, flush, redirect_valid, redirect_pc, halt_req,
    input  imem_addr, program_counter, if_id_instr, if_id_pc, if_id_pc4,
           if_id_valid, pc_misalign, cycle_count
  );

endinterface

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst_n   - clock, asynchronous active-low reset (clears everything)
//   i_hold       - keep all fields (stall)
//   i_clr_valid  - drop valid, data fields keep their value (flush/redirect/halt)
//   i_d / o_q    - next / current register contents
// Clearing valid outranks holding so a squash during a stall still kills
// the held instruction.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_hold,
  input  logic   i_clr_valid,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  // IF/ID storage with squash > hold > load priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr_valid) begin
      r_q.valid <= 1'b0;
    end else if (i_hold) begin
      r_q <= r_q;
    end else begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS instruction-fetch stage. Owns the program counter,
// addresses instruction memory and loads the IF/ID register.
//   clk    - pipeline clock
//   rst_n  - asynchronous active-low reset
//   bus    - fetch_stage_if.master (memory bus, stall/flush/redirect/halt
//            controls, IF/ID outputs, pc_misalign pulse, cycle_count)
// Optional feature: define FETCH_CYCLE_CNT_EN to build the S_RUN cycle
// counter; otherwise cycle_count is tied to zero.
module fetch_stage
  import mips_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [XLEN-1:0] w_pc_next;
  logic            w_clr_valid;
  if_id_t          w_if_id_d;
  if_id_t          w_if_id_q;

  // Sequential PC; wraps modulo 2^XLEN without any flag.
  assign w_pc_next = r_pc + PC_STEP;

  // Valid is dropped outside S_RUN and whenever the fetched word is wrong-path.
  assign w_clr_valid = (r_state != S_RUN) | bus.halt_req | bus.redirect_valid | bus.flush;

  assign w_if_id_d.instr = bus.imem_rdata;
  assign w_if_id_d.pc    = r_pc;
  assign w_if_id_d.pc4   = w_pc_next;
  assign w_if_id_d.valid = 1'b1;

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_hold      (bus.stall),
    .i_clr_valid (w_clr_valid),
    .i_d         (w_if_id_d),
    .o_q         (w_if_id_q)
  );

  // Fetch FSM, program counter and misalign pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_pc       <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        S_INIT: begin
          r_pc    <= align_word(bus.pc_init);
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (bus.halt_req) begin
            r_state <= S_HALT;
          end else if (bus.redirect_valid) begin
            r_pc       <= align_word(bus.redirect_pc);
            r_misalign <= (bus.redirect_pc[1:0] != 2'b00);
          end else if (!bus.stall) begin
            r_pc <= w_pc_next;
          end else begin
            r_pc <= r_pc;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

`ifdef FETCH_CYCLE_CNT_EN
  logic [31:0] r_cycle_cnt;

  // Counts every edge spent in S_RUN, stalls included; frozen elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= 32'd0;
    end else if (r_state == S_RUN) begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end else begin
      r_cycle_cnt <= r_cycle_cnt;
    end
  end

  assign bus.cycle_count = r_cycle_cnt;
`else
  assign bus.cycle_count = 32'd0;
`endif

  assign bus.imem_addr       = r_pc;
  assign bus.program_counter = r_pc;
  assign bus.pc_misalign     = r_misalign;
  assign bus.if_id_instr     = w_if_id_q.instr;
  assign bus.if_id_pc        = w_if_id_q.pc;
  assign bus.if_id_pc4       = w_if_id_q.pc4;
  assign bus.if_id_valid     = w_if_id_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. Instruction memory returns
// addr ^ 32'hA5A5_0000 so every fetched word is address-specific.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;

  fetch_stage_if ifc ();

  fetch_stage u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  assign ifc.imem_rdata = ifc.imem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    ifc.pc_init        = 32'd656;
    ifc.stall          = 1'b0;
    ifc.flush          = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = 32'd0;
    ifc.halt_req       = 1'b0;

    step(); step();
    check("rst_pc", ifc.program_counter, 32'd0);
    check("rst_valid", {31'd0, ifc.if_id_valid}, 32'd0);
    check("rst_ifid_pc", ifc.if_id_pc, 32'd0);
    check("rst_misalign", {31'd0, ifc.pc_misalign}, 32'd0);
    check("rst_cnt", ifc.cycle_count, 32'd0);

    // Start-up
    rst_n = 1'b1;
    step();
    check("init_pc", ifc.program_counter, 32'd656);
    check("init_valid", {31'd0, ifc.if_id_valid}, 32'd0);
    step();
    check("f1_ifid_pc", ifc.if_id_pc, 32'd656);
    check("f1_instr", ifc.if_id_instr, 32'hA5A5_0290);
    check("f1_pc4", ifc.if_id_pc4, 32'd660);
    check("f1_valid", {31'd0, ifc.if_id_valid}, 32'd1);
    check("f1_pc", ifc.program_counter, 32'd660);
    step();
    check("f2_pc", ifc.program_counter, 32'd664);
    check("f2_ifid_pc", ifc.if_id_pc, 32'd660);

    // Stall for two cycles at PC=664
    ifc.stall = 1'b1;
    step();
    check("st1_pc", ifc.program_counter, 32'd664);
    check("st1_ifid_pc", ifc.if_id_pc, 32'd660);
    check("st1_valid", {31'd0, ifc.if_id_valid}, 32'd1);
    step();
    check("st2_pc", ifc.program_counter, 32'd664);
    check("st2_instr", ifc.if_id_instr, 32'hA5A5_0294);
    ifc.stall = 1'b0;
    step();
    check("st_rel_ifid_pc", ifc.if_id_pc, 32'd664);
    check("st_rel_pc", ifc.program_counter, 32'd668);

    // Redirect overrides a simultaneous stall
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'd700;
    ifc.stall          = 1'b1;
    step();
    check("rd_pc", ifc.program_counter, 32'd700);
    check("rd_valid", {31'd0, ifc.if_id_valid}, 32'd0);
    check("rd_misalign", {31'd0, ifc.pc_misalign}, 32'd0);
    ifc.redirect_valid = 1'b0;
    ifc.stall          = 1'b0;
    step();
    check("rd_ifid_pc", ifc.if_id_pc, 32'd700);
    check("rd_instr", ifc.if_id_instr, 32'hA5A5_02BC);
    check("rd_valid2", {31'd0, ifc.if_id_valid}, 32'd1);
    check("rd_pc2", ifc.program_counter, 32'd704);

    // Misaligned redirect target
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'h0000_02BE;
    step();
    check("mis_pc", ifc.program_counter, 32'h0000_02BC);
    check("mis_pulse", {31'd0, ifc.pc_misalign}, 32'd1);
    check("mis_valid", {31'd0, ifc.if_id_valid}, 32'd0);
    ifc.redirect_valid = 1'b0;
    step();
    check("mis_pulse_end", {31'd0, ifc.pc_misalign}, 32'd0);
    check("mis_ifid_pc", ifc.if_id_pc, 32'h0000_02BC);
    check("mis_pc2", ifc.program_counter, 32'h0000_02C0);

    // Flush without stall: squash, PC advances
    ifc.flush = 1'b1;
    step();
    check("fl_valid", {31'd0, ifc.if_id_valid}, 32'd0);
    check("fl_pc", ifc.program_counter, 32'h0000_02C4);
    ifc.flush = 1'b0;

    // Move to PC=680, then reset mid-run
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'd680;
    step();
    ifc.redirect_valid = 1'b0;
    check("pre_rst_pc", ifc.program_counter, 32'd680);
    step();
    check("pre_rst_valid", {31'd0, ifc.if_id_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", ifc.program_counter, 32'd0);
    check("mid_rst_valid", {31'd0, ifc.if_id_valid}, 32'd0);
    check("mid_rst_ifid_pc", ifc.if_id_pc, 32'd0);

    // Restart at the top of the address space to exercise the wrap
    ifc.pc_init = 32'hFFFF_FFFC;
    #1;
    rst_n = 1'b1;
    step();
    check("wr_init_pc", ifc.program_counter, 32'hFFFF_FFFC);
    step();
    check("wr_ifid_pc", ifc.if_id_pc, 32'hFFFF_FFFC);
    check("wr_pc4", ifc.if_id_pc4, 32'd0);
    check("wr_pc", ifc.program_counter, 32'd0);
    check("wr_valid", {31'd0, ifc.if_id_valid}, 32'd1);

    // Halt: valid drops, PC and counter freeze
    ifc.halt_req = 1'b1;
    step();
    ifc.halt_req = 1'b0;
    check("h_valid", {31'd0, ifc.if_id_valid}, 32'd0);
    check("h_pc", ifc.program_counter, 32'd0);
`ifdef FETCH_CYCLE_CNT_EN
    exp_cnt = 32'd2;
`else
    exp_cnt = 32'd0;
`endif
    ifc.stall          = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = 32'd500;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_pc", ifc.program_counter, 32'd0);
      check("hold_valid", {31'd0, ifc.if_id_valid}, 32'd0);
    end
    check("hold_cnt", ifc.cycle_count, exp_cnt);
    ifc.redirect_valid = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
